regfile_wb_arbiter: RTL and testbench
=====================================

# regfile_wb_arbiter

Write-back arbiter for the 32×32 register file. Two write-back sources share the register file's single write port (we/rwaddr/din): requester A (ALU result path) and requester B (load/LSU return path). Each source has a one-entry holding buffer. A registered grant stage drives the register file. A busy mask tells decode which registers still have a write in flight.

## Interface
Parameters:
- none (address width 5, data width 32, fixed to match the register file)

Ports:
- clk  in  1  rising-edge clock; the same clock as the register file
- rst  in  1  synchronous, active-high reset
- a_valid  in  1  requester A offers a write
- a_ready  out  1  A's buffer can accept this cycle
- a_addr  in  5  A's destination register
- a_data  in  32  A's write data
- b_valid  in  1  requester B offers a write
- b_ready  out  1  B's buffer can accept this cycle
- b_addr  in  5  B's destination register
- b_data  in  32  B's write data
- rf_we  out  1  register-file write enable (registered)
- rf_waddr  out  5  register-file write address (registered)
- rf_wdata  out  32  register-file write data (registered)
- busy_mask  out  32  bit i = 1 while a write to register i is buffered or on rf_*

## Operation
- Handshake: a transfer happens on a rising edge when valid && ready. Data and address are sampled at that edge. valid may drop at any time without penalty.
- x_ready = !x_full || x_grant. x_grant is combinational from buffer state, so a buffer drained this cycle can refill at the same edge.
- Address 0: the transfer is accepted and discarded. The buffer stays empty and no rf_we pulse is produced.
- Grant, combinational each cycle:
  - only one buffer full → grant it
  - both full → arbitration rule (see Configuration)
  - neither full → no grant
- On the edge with a grant:
  - rf_we <= 1, rf_waddr/rf_wdata <= granted entry
  - the granted buffer is cleared, unless refilled at the same edge
- With no grant, rf_we <= 0 and rf_waddr/rf_wdata hold their values.
- busy_mask is combinational and is the OR of:
  - onehot(a_addr_buf) when A is full
  - onehot(b_addr_buf) when B is full
  - onehot(rf_waddr) when rf_we = 1
  - bit 0 is always 0.
- Same-address writes from A and B are performed in grant order; the later grant wins in the register file. Sources that need a different order must stall on busy_mask.

## Timing
- Reset values:
  - a_ready = b_ready = 1, since both buffers are empty
  - rf_we = 0, rf_waddr = 0, rf_wdata = 0
  - busy_mask = 0
  - round-robin pointer favours A
- Reset asserted mid-operation discards both buffers and any pending rf_we. No write reaches the register file on the edge after rst is sampled high.
- Latency, uncontended: accepted at edge N → rf_we = 1 during cycle N+1 → register file written at edge N+2.
- Throughput: one write per cycle total. A single active source sustains one write per cycle.
- Losing requester: holds its buffer and deasserts ready until granted. Bounded by 1 cycle under round-robin; unbounded under fixed priority.

## Configuration
- WB_RR_ARB_EN defined: round-robin arbitration.
  - A 1-bit pointer records the last grantee.
  - When both buffers are full, the other requester wins.
  - The pointer updates only on grants made with both buffers full.
- WB_RR_ARB_EN undefined: fixed priority. A always wins when both buffers are full, and B may starve.

## Test plan
- Single write: A sends addr 5 data 0xDEADBEEF. Required: rf_we = 1 with rf_waddr = 5 one cycle later, busy_mask[5] set for 2 cycles, then cleared.
- Address 0: B sends addr 0 data 0x1234. Required: b_ready stays 1, rf_we stays 0, busy_mask stays 0.
- Contention, both buffers full (A: r3 = 0x11, B: r3 = 0x22):
  - fixed priority: A is written, then B; r3 ends at 0x22
  - WB_RR_ARB_EN with pointer at A: B is written first, then A; r3 ends at 0x11
- Streaming: A valid every cycle for 8 cycles with B idle. Required: a_ready stays 1 and there are 8 consecutive rf_we pulses.
- Starvation check: A and B both continuously valid for 10 cycles.
  - WB_RR_ARB_EN: grants alternate A/B
  - fixed priority: B is never granted while A streams
- Reset mid-flight: with both buffers full, raise rst for 1 cycle. Required: no rf_we on the following edges, busy_mask = 0, both ready signals = 1.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_arbiter
// Brief    : Two-source write-back arbiter for the 32x32 register file, with
//            one-entry holding buffers, registered write port and busy mask.
//            WB_RR_ARB_EN selects round-robin; fixed A-priority otherwise.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic [4:0]  a_addr,
  input  logic [31:0] a_data,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic [4:0]  b_addr,
  input  logic [31:0] b_data,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [31:0] busy_mask
);

  logic        r_a_full;
  logic [4:0]  r_a_addr;
  logic [31:0] r_a_data;
  logic        r_b_full;
  logic [4:0]  r_b_addr;
  logic [31:0] r_b_data;

  logic        w_a_wins;
  logic        w_a_grant;
  logic        w_b_grant;
  logic        w_a_take;
  logic        w_b_take;
  logic [31:0] w_busy;

`ifdef WB_RR_ARB_EN
  // Pointer holds the last grantee of a contended cycle; reset value favours A.
  logic r_last_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_b <= 1'b1;
    end else if (r_a_full && r_b_full) begin
      r_last_b <= w_b_grant;
    end
  end

  assign w_a_wins = r_last_b;
`else
  assign w_a_wins = 1'b1;
`endif

  assign w_a_grant = r_a_full && (!r_b_full || w_a_wins);
  assign w_b_grant = r_b_full && !w_a_grant;

  assign a_ready = !r_a_full || w_a_grant;
  assign b_ready = !r_b_full || w_b_grant;

  assign w_a_take = a_valid && a_ready;
  assign w_b_take = b_valid && b_ready;

  // A transfer to r0 is consumed but never occupies the buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_full <= 1'b0;
      r_a_addr <= 5'd0;
      r_a_data <= 32'd0;
    end else if (w_a_take) begin
      r_a_full <= (a_addr != 5'd0);
      r_a_addr <= a_addr;
      r_a_data <= a_data;
    end else if (w_a_grant) begin
      r_a_full <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_b_full <= 1'b0;
      r_b_addr <= 5'd0;
      r_b_data <= 32'd0;
    end else if (w_b_take) begin
      r_b_full <= (b_addr != 5'd0);
      r_b_addr <= b_addr;
      r_b_data <= b_data;
    end else if (w_b_grant) begin
      r_b_full <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we    <= 1'b0;
      rf_waddr <= 5'd0;
      rf_wdata <= 32'd0;
    end else if (w_a_grant) begin
      rf_we    <= 1'b1;
      rf_waddr <= r_a_addr;
      rf_wdata <= r_a_data;
    end else if (w_b_grant) begin
      rf_we    <= 1'b1;
      rf_waddr <= r_b_addr;
      rf_wdata <= r_b_data;
    end else begin
      rf_we    <= 1'b0;
    end
  end

  always_comb begin
    w_busy = 32'd0;
    if (r_a_full) w_busy[r_a_addr] = 1'b1;
    if (r_b_full) w_busy[r_b_addr] = 1'b1;
    if (rf_we)    w_busy[rf_waddr] = 1'b1;
    w_busy[0] = 1'b0;
  end

  assign busy_mask = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_wb_arbiter
// Brief    : Scoreboard bench for regfile_wb_arbiter with a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, b_valid;
  logic        a_ready, b_ready;
  logic [4:0]  a_addr, b_addr;
  logic [31:0] a_data, b_data;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] busy_mask;

  always #5 clk = ~clk;

  regfile_wb_arbiter dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .busy_mask(busy_mask)
  );

`ifdef WB_RR_ARB_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct packed { logic [4:0] addr; logic [31:0] data; } wr_t;
  typedef struct { logic [4:0] addr; logic [31:0] data; int cyc; } exp_t;

  wr_t         pa[$];
  wr_t         pb[$];
  exp_t        exp_q[$];
  bit          fl_v = 1'b0;
  logic [4:0]  fl_addr = 5'd0;
  bit          last_b = 1'b1;
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;
  logic [31:0] obs_rf [32];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Monitor: every write the DUT presents must match the oldest expected one.
  initial begin
    forever begin
      @(negedge clk);
      if (rf_we === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write cyc=%0d: got addr=%0d data=%h expected no write",
                   cyc, rf_waddr, rf_wdata);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (rf_waddr !== e.addr || rf_wdata !== e.data || cyc != e.cyc) begin
            errors++;
            $display("FAIL write cyc=%0d: got addr=%0d data=%h expected addr=%0d data=%h at cyc=%0d",
                     cyc, rf_waddr, rf_wdata, e.addr, e.data, e.cyc);
          end
        end
        obs_rf[rf_waddr] = rf_wdata;
      end
    end
  end

  // One cycle of stimulus plus the model's view of that cycle.
  task automatic step(input bit r,
                      input bit av, input logic [4:0] aa, input logic [31:0] ad,
                      input bit bv, input logic [4:0] ba, input logic [31:0] bd);
    int          win;
    bit          era, erb, both;
    logic [31:0] ebusy;
    wr_t         w;
    @(negedge clk);
    rst = r;
    a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
    #1;
    both = (pa.size() != 0) && (pb.size() != 0);
    if (both)                 win = (RR && !last_b) ? 2 : 1;
    else if (pa.size() != 0)  win = 1;
    else if (pb.size() != 0)  win = 2;
    else                      win = 0;
    era = (pa.size() == 0) || (win == 1);
    erb = (pb.size() == 0) || (win == 2);
    ebusy = 32'd0;
    foreach (pa[i]) ebusy[pa[i].addr] = 1'b1;
    foreach (pb[i]) ebusy[pb[i].addr] = 1'b1;
    if (fl_v) ebusy[fl_addr] = 1'b1;
    ebusy[0] = 1'b0;
    chk("a_ready", {31'd0, a_ready}, {31'd0, era});
    chk("b_ready", {31'd0, b_ready}, {31'd0, erb});
    chk("busy_mask", busy_mask, ebusy);
    if (r) begin
      pa.delete();
      pb.delete();
      fl_v = 1'b0;
      last_b = 1'b1;
    end else begin
      fl_v = 1'b0;
      if (win == 1) begin
        w = pa.pop_front();
        exp_q.push_back('{w.addr, w.data, cyc + 1});
        fl_v = 1'b1; fl_addr = w.addr;
      end else if (win == 2) begin
        w = pb.pop_front();
        exp_q.push_back('{w.addr, w.data, cyc + 1});
        fl_v = 1'b1; fl_addr = w.addr;
      end
      if (both) last_b = (win == 2);
      if (av && era && aa != 5'd0) pa.push_back('{aa, ad});
      if (bv && erb && ba != 5'd0) pb.push_back('{ba, bd});
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) obs_rf[i] = 32'd0;
    rst = 1'b1;
    a_valid = 1'b0; a_addr = 5'd0; a_data = 32'd0;
    b_valid = 1'b0; b_addr = 5'd0; b_data = 32'd0;
    repeat (3) @(posedge clk);

    // Reset state checked on the first step; then a single write.
    step(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
    idle(3);

    // Address 0 from B is consumed without a write.
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h1234);
    idle(2);

    // Contention on r3 from reset: A is favoured in both modes.
    step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    step(1'b0, 1'b1, 5'd3, 32'h11, 1'b1, 5'd3, 32'h22);
    idle(4);
    chk("r3_first_contention", obs_rf[3], 32'h22);
    // Second contention: round-robin pointer now at A, so B goes first.
    step(1'b0, 1'b1, 5'd3, 32'h11, 1'b1, 5'd3, 32'h22);
    idle(4);
    chk("r3_second_contention", obs_rf[3], RR ? 32'h11 : 32'h22);

    // Streaming from A alone.
    for (int i = 0; i < 8; i++)
      step(1'b0, 1'b1, 5'(i + 1), $urandom, 1'b0, 5'd0, 32'd0);
    idle(3);

    // Both sources continuously valid.
    for (int i = 0; i < 10; i++)
      step(1'b0, 1'b1, 5'(i + 1), {1'b0, 31'($urandom)},
                 1'b1, 5'(i + 11), {1'b1, 31'($urandom)});
    idle(4);

    // Reset with both buffers full.
    step(1'b0, 1'b1, 5'd7, 32'hA7, 1'b1, 5'd8, 32'hB8);
    step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    idle(3);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 400; i++)
      step($urandom_range(63) == 0,
           1'($urandom), 5'($urandom_range(31)), $urandom,
           1'($urandom), 5'($urandom_range(31)), $urandom);
    idle(5);

    chk("pending_writes_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
